// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: core MEM stage (fixed priority) vs host/debug port.
// Starvation-forced host slot, host lock, tagged one-cycle read return.
//
// Ports:
//   clk, rstn              clock, async active-low reset
//   core_req/we/addr/wdata core access; core_stall holds the pipeline
//   core_rvalid/rdata      core read return
//   host_req/we/addr/wdata host access, held until host_gnt
//   host_lock              host owns the RAM, core frozen
//   host_gnt               host access taken this cycle
//   host_rvalid/rdata      host read return
//   ram_en/we/addr/wdata   RAM command
//   ram_rdata              registered read-first RAM data
module dmem_arbiter #(
  parameter int MEM_WA       = 8,
  parameter int WIDTH_VECTOR = 16,
  parameter int N            = 16,
  parameter int STARVE_MAX   = 4,
  localparam int DW          = WIDTH_VECTOR * N
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [MEM_WA-1:0] core_addr,
  input  logic [DW-1:0]     core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DW-1:0]     core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [MEM_WA-1:0] host_addr,
  input  logic [DW-1:0]     host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DW-1:0]     host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [MEM_WA-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    NORMAL,
    FORCE_HOST,
    LOCK
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_HOST
  } owner_t;

  state_t        state;
  state_t        state_nxt;
  owner_t        rd_owner;
  owner_t        owner_nxt;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] cnt_nxt;
  logic [DW-1:0] core_rdata_q;
  logic [DW-1:0] host_rdata_q;

  logic force_slot;
  logic core_gnt;

  // Lock acts on the live host_lock; the LOCK state only tracks it.
  // Grants are masked by rstn so the RAM sees nothing during reset.
  assign force_slot = (state == FORCE_HOST) & host_req;

  assign host_gnt = rstn & host_req
                  & (host_lock | force_slot | ~core_req);

  assign core_gnt = rstn & core_req
                  & ~host_lock & ~force_slot;

  assign core_stall = host_lock | (core_req & force_slot);

  always_comb begin
    ram_en    = host_gnt | core_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      host_gnt: begin
        ram_we    = host_we;
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
      end
      core_gnt: begin
        ram_we    = core_we;
        ram_addr  = core_addr;
        ram_wdata = core_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_nxt = starve_cnt;
    if (host_lock || host_gnt)
      cnt_nxt = '0;
    else if (host_req && starve_cnt != CNT_MAX)
      cnt_nxt = starve_cnt + CW'(1);
  end

  // FORCE_HOST is entered on the edge where the count reaches its
  // limit, so the forced slot lands exactly STARVE_MAX cycles after
  // the host first lost arbitration.
  always_comb begin
    state_nxt = NORMAL;
    if (host_lock)
      state_nxt = LOCK;
    else if (host_req && !host_gnt && cnt_nxt == CNT_MAX)
      state_nxt = FORCE_HOST;
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    if (host_gnt && !host_we)
      owner_nxt = OWN_HOST;
    else if (core_gnt && !core_we)
      owner_nxt = OWN_CORE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= NORMAL;
      starve_cnt   <= '0;
      rd_owner     <= OWN_NONE;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
      rd_owner   <= owner_nxt;
      if (core_rvalid)
        core_rdata_q <= ram_rdata;
      if (host_rvalid)
        host_rdata_q <= ram_rdata;
    end
  end

  // RAM data arrives the cycle after the read grant; the idle side
  // keeps presenting its last returned word.
  assign core_rvalid = (rd_owner == OWN_CORE);
  assign host_rvalid = (rd_owner == OWN_HOST);
  assign core_rdata  = core_rvalid ? ram_rdata : core_rdata_q;
  assign host_rdata  = host_rvalid ? ram_rdata : host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: vector table plus lock and reset
// sequences against a behavioural read-first RAM.
module tb_dmem_arbiter;

  localparam int WA = 8;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic [WA-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_stall;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [WA-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_lock = 1'b0;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [WA-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .MEM_WA(WA),
    .WIDTH_VECTOR(16),
    .N(16),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .core_req(core_req),
    .core_we(core_we),
    .core_addr(core_addr),
    .core_wdata(core_wdata),
    .core_stall(core_stall),
    .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .host_req(host_req),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_lock(host_lock),
    .host_gnt(host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .ram_en(ram_en),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  logic [DW-1:0] mem [256];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we)
        mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  function automatic logic [DW-1:0] pat(input logic [7:0] s);
    return {32{s}};
  endfunction

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       creq;
    logic       cwe;
    logic [7:0] caddr;
    logic [7:0] cseed;
    logic       hreq;
    logic       hwe;
    logic [7:0] haddr;
    logic [7:0] hseed;
    logic       stall;
    logic       gnt;
    logic       crv;
    logic       hrv;
    logic [7:0] cdat;
    logic [7:0] hdat;
  } vec_t;

  function automatic vec_t mk(
    input logic cr, input logic cw,
    input logic [7:0] ca, input logic [7:0] cs,
    input logic hr, input logic hw,
    input logic [7:0] ha, input logic [7:0] hs,
    input logic st, input logic g,
    input logic crv, input logic hrv,
    input logic [7:0] cd, input logic [7:0] hd);
    vec_t v;
    v.creq = cr;  v.cwe = cw;
    v.caddr = ca; v.cseed = cs;
    v.hreq = hr;  v.hwe = hw;
    v.haddr = ha; v.hseed = hs;
    v.stall = st; v.gnt = g;
    v.crv = crv;  v.hrv = hrv;
    v.cdat = cd;  v.hdat = hd;
    return v;
  endfunction

  task automatic drive(input logic cr, input logic cw,
                       input logic [7:0] ca, input logic [7:0] cs,
                       input logic hr, input logic hw,
                       input logic [7:0] ha, input logic [7:0] hs);
    core_req   = cr;
    core_we    = cw;
    core_addr  = ca;
    core_wdata = pat(cs);
    host_req   = hr;
    host_we    = hw;
    host_addr  = ha;
    host_wdata = pat(hs);
  endtask

  vec_t tbl [$];

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = '0;

    // host-only: write then read-after-write, then preload
    tbl.push_back(mk(0,0,8'h00,8'h00, 1,1,8'h05,8'hA1,
                     0,1,0,0, 8'h00,8'h00));
    tbl.push_back(mk(0,0,8'h00,8'h00, 1,0,8'h05,8'h00,
                     0,1,0,0, 8'h00,8'h00));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00,
                     0,0,0,1, 8'h00,8'hA1));
    tbl.push_back(mk(0,0,8'h00,8'h00, 1,1,8'h10,8'hB2,
                     0,1,0,0, 8'h00,8'hA1));
    tbl.push_back(mk(0,0,8'h00,8'h00, 1,1,8'h11,8'hC3,
                     0,1,0,0, 8'h00,8'hA1));
    tbl.push_back(mk(0,0,8'h00,8'h00, 1,1,8'h12,8'hD4,
                     0,1,0,0, 8'h00,8'hA1));
    tbl.push_back(mk(0,0,8'h00,8'h00, 1,1,8'h20,8'hE5,
                     0,1,0,0, 8'h00,8'hA1));
    tbl.push_back(mk(0,0,8'h00,8'h00, 1,1,8'h30,8'hF6,
                     0,1,0,0, 8'h00,8'hA1));
    // core-only back-to-back reads
    tbl.push_back(mk(1,0,8'h10,8'h00, 0,0,8'h00,8'h00,
                     0,0,0,0, 8'h00,8'hA1));
    tbl.push_back(mk(1,0,8'h11,8'h00, 0,0,8'h00,8'h00,
                     0,0,1,0, 8'hB2,8'hA1));
    tbl.push_back(mk(1,0,8'h12,8'h00, 0,0,8'h00,8'h00,
                     0,0,1,0, 8'hC3,8'hA1));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00,
                     0,0,1,0, 8'hD4,8'hA1));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00,
                     0,0,0,0, 8'hD4,8'hA1));
    // starvation: host raised at row 14, forced at row 18
    tbl.push_back(mk(1,0,8'h20,8'h00, 0,0,8'h00,8'h00,
                     0,0,0,0, 8'hD4,8'hA1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1,0,8'h20,8'h00, 1,0,8'h30,8'h00,
                       0,0,1,0, 8'hE5,8'hA1));
    tbl.push_back(mk(1,0,8'h20,8'h00, 1,0,8'h30,8'h00,
                     1,1,1,0, 8'hE5,8'hA1));
    tbl.push_back(mk(1,0,8'h20,8'h00, 0,0,8'h00,8'h00,
                     0,0,0,1, 8'hE5,8'hF6));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00,
                     0,0,1,0, 8'hE5,8'hF6));
    // second starvation episode: counter restarted from zero
    tbl.push_back(mk(1,0,8'h10,8'h00, 1,0,8'h05,8'h00,
                     0,0,0,0, 8'hE5,8'hF6));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,0,8'h10,8'h00, 1,0,8'h05,8'h00,
                       0,0,1,0, 8'hB2,8'hF6));
    tbl.push_back(mk(1,0,8'h10,8'h00, 1,0,8'h05,8'h00,
                     1,1,1,0, 8'hB2,8'hF6));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00,
                     0,0,0,1, 8'hB2,8'hA1));
    tbl.push_back(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00,
                     0,0,0,0, 8'hB2,8'hA1));

    // reset state
    #2;
    chk("rst_stall", DW'(core_stall), DW'(0));
    chk("rst_gnt", DW'(host_gnt), DW'(0));
    chk("rst_en", DW'(ram_en), DW'(0));
    chk("rst_crv", DW'(core_rvalid), DW'(0));
    chk("rst_hrv", DW'(host_rvalid), DW'(0));
    chk("rst_cdat", core_rdata, '0);
    #10 rstn = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      drive(tbl[i].creq, tbl[i].cwe, tbl[i].caddr,
            tbl[i].cseed, tbl[i].hreq, tbl[i].hwe,
            tbl[i].haddr, tbl[i].hseed);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), DW'(core_stall),
          DW'(tbl[i].stall));
      chk($sformatf("v%0d_gnt", i), DW'(host_gnt),
          DW'(tbl[i].gnt));
      chk($sformatf("v%0d_crv", i), DW'(core_rvalid),
          DW'(tbl[i].crv));
      chk($sformatf("v%0d_hrv", i), DW'(host_rvalid),
          DW'(tbl[i].hrv));
      chk($sformatf("v%0d_cdat", i), core_rdata,
          pat(tbl[i].cdat));
      chk($sformatf("v%0d_hdat", i), host_rdata,
          pat(tbl[i].hdat));
    end

    // lock: 10 cycles, core frozen, 8 host writes
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      host_lock = 1'b1;
      drive(1, 1, 8'h40, 8'h77,
            (i >= 1 && i <= 8), 1,
            8'(8'h4F + i), 8'(8'h80 + i));
      @(negedge clk);
      chk($sformatf("lk%0d_stall", i), DW'(core_stall), DW'(1));
      chk($sformatf("lk%0d_gnt", i), DW'(host_gnt),
          DW'(i >= 1 && i <= 8));
    end
    @(posedge clk);
    #1;
    host_lock = 1'b0;
    drive(1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("unlk_stall", DW'(core_stall), DW'(0));
    chk("unlk_en", DW'(ram_en), DW'(1));
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      drive(k < 9, 0, (k < 8) ? 8'(8'h50 + k) : 8'h40,
            8'h00, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      chk($sformatf("lkrd%0d_crv", k), DW'(core_rvalid), DW'(1));
      chk($sformatf("lkrd%0d_dat", k), core_rdata,
          (k < 9) ? pat(8'(8'h80 + k)) : '0);
    end

    // reset with a host read outstanding
    @(posedge clk);
    #1;
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00);
    @(negedge clk);
    chk("rr_gnt", DW'(host_gnt), DW'(1));
    @(posedge clk);
    #1;
    rstn = 1'b0;
    drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    #1;
    chk("rr_hrv", DW'(host_rvalid), DW'(0));
    chk("rr_crv", DW'(core_rvalid), DW'(0));
    chk("rr_en", DW'(ram_en), DW'(0));
    chk("rr_we", DW'(ram_we), DW'(0));
    chk("rr_stall", DW'(core_stall), DW'(0));
    chk("rr_hdat", host_rdata, '0);
    host_lock = 1'b1;
    #1;
    chk("rr_lkstall", DW'(core_stall), DW'(1));
    host_lock = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rr_post_hrv", DW'(host_rvalid), DW'(0));
    chk("rr_post_stall", DW'(core_stall), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the core's single-port vector data RAM between two requesters: the pipeline MEM stage (core) and an external host/debug port used for preload and dump.
- Sits between the core's MEM stage and the RAM instance.
- Core has fixed priority. A starvation counter guarantees the host a slot; when the core loses a cycle, the block stalls it by deasserting the pipeline advance enable.
- Read data returns one cycle after grant and is routed to the requester that issued the read.

Parameters:
- MEM_WA, 8, RAM word address width
- WIDTH_VECTOR, 16, lanes per word
- N, 16, bits per lane; RAM data width is DW = WIDTH_VECTOR*N
- STARVE_MAX, 4, consecutive cycles a host request may be denied before it is forced through (must be ≥1)

Ports:
- clk, in, 1, clock
- rstn, in, 1, asynchronous active-low reset
- core_req, in, 1, core access request this cycle
- core_we, in, 1, 1=write, 0=read
- core_addr, in, MEM_WA, core word address
- core_wdata, in, DW, core write data
- core_stall, out, 1, core request not serviced this cycle; core must hold its pipeline
- core_rvalid, out, 1, core read data valid
- core_rdata, out, DW, core read data
- host_req, in, 1, host request; must stay stable until host_gnt
- host_we, in, 1, 1=write, 0=read
- host_addr, in, MEM_WA, host word address
- host_wdata, in, DW, host write data
- host_lock, in, 1, host owns the RAM exclusively (program/data load)
- host_gnt, out, 1, host request accepted this cycle
- host_rvalid, out, 1, host read data valid
- host_rdata, out, DW, host read data
- ram_en, out, 1, RAM access strobe
- ram_we, out, 1, RAM write enable
- ram_addr, out, MEM_WA, RAM address
- ram_wdata, out, DW, RAM write data
- ram_rdata, in, DW, RAM read data; registered, valid 1 cycle after a read with ram_en=1; read-first

Behaviour:
- Reset (async):
  - FSM to NORMAL; starve_cnt=0; rd_owner=NONE.
  - core_rvalid, host_rvalid, host_gnt, ram_en and ram_we are 0. core_stall is 0 unless host_lock=1, since core_stall is combinational.
  - Data outputs are 0 while in reset.
- Arbitration and RAM mux are combinational and decided in the same cycle. At most one access per cycle.
- FSM states:
  - NORMAL: if core_req, grant core; core_stall=0. Else if host_req, grant host.
  - FORCE_HOST: entered when starve_cnt==STARVE_MAX and host_req=1. Host is granted even if core_req=1; core_stall=core_req. Returns to NORMAL on the next cycle (exactly one forced slot).
  - LOCK: entered whenever host_lock=1, from any state. The host is granted whenever host_req=1. core_stall=1 regardless of core_req, so the pipeline is frozen. Exits to NORMAL the cycle after host_lock falls. starve_cnt=0 while in LOCK.
- starve_cnt:
  - Increments each cycle host_req=1 and host_gnt=0.
  - Clears on host_gnt.
  - Saturates at STARVE_MAX.
  - Width is $clog2(STARVE_MAX+1).
- Grant effects:
  - ram_en=1.
  - ram_we, ram_addr and ram_wdata come from the granted requester.
  - host_gnt=1 for exactly the granted cycle.
  - With no grant, ram_en=0 and ram_we=0.
- Read return:
  - On a read grant, rd_owner is registered as CORE or HOST.
  - Next cycle, <owner>_rvalid=1 and <owner>_rdata=ram_rdata. The other requester's rvalid=0 and its rdata holds its last value.
  - Writes produce no rvalid.
  - Back-to-back reads give rvalid every cycle, each correctly tagged.
- Hazards:
  - A same-address write followed next cycle by a read returns the new data.
  - A read and a write never share a cycle, so no forwarding is needed.
- Simultaneous core_req and host_req in NORMAL with starve_cnt<STARVE_MAX: core wins, host waits, and the counter increments.
- Reset asserted with a read outstanding: the rvalid is dropped and is not re-issued.

Test Plan:
- Host-only traffic: host write addr 0x05 = pattern A, then host read 0x05 → host_gnt every request cycle; host_rvalid=1 one cycle after the read with rdata=A; core_rvalid stays 0.
- Core-only traffic: core reads 0x10, 0x11, 0x12 back-to-back (preloaded) → core_stall=0 throughout; core_rvalid on 3 consecutive cycles with the matching data.
- Starvation with STARVE_MAX=4: core_req held 1 continuously and host_req raised at cycle t → host_gnt at cycle t+4; core_stall=1 only in that cycle; starve_cnt returns to 0.
- host_lock=1 for 10 cycles with core_req=1 and 8 host writes → core_stall=1 for all 10 cycles; all 8 host writes land; first cycle after host_lock=0 grants the core.
- Mixed readers: core read 0x20 in cycle t, forced host read 0x30 in cycle t+1 → core_rvalid at t+1 with mem[0x20]; host_rvalid at t+2 with mem[0x30]; no cross-routing.
- Reset mid-read: rstn pulsed low the cycle after a host read grant → host_rvalid never asserts; all flags 0; after release, core_stall=0 when host_lock=0.
